// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, MIPS opcode/funct encodings and sequencer states
//
// Purpose: common constants for the ALU control decoder and the issue sequencer.
// Ports: none (package).
package alu_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type funct codes, instr[5:0]
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// rtl/alu_ctl_decode.sv - combinational MIPS opcode/funct to ALU control decoder
//
// Purpose: maps one instruction word to ALU control code, operand-B select,
//          register write-back control, branch flag and illegal flag.
// Ports:
//   instr     in  32  instruction word
//   alu_ctl   out 4   ALU control code (ADD when illegal)
//   use_imm   out 1   operand B is the sign-extended immediate
//   wr_en     out 1   instruction writes a register
//   wr_reg    out 5   destination register (rd for R-type, rt otherwise)
//   is_branch out 1   instruction is beq
//   illegal   out 1   instruction cannot be decoded
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_ctl,
  output logic        use_imm,
  output logic        wr_en,
  output logic [4:0]  wr_reg,
  output logic        is_branch,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  // rs and shamt do not influence control decode
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    alu_ctl   = ALU_ADD;
    use_imm   = 1'b0;
    wr_en     = 1'b0;
    wr_reg    = 5'd0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_RTYPE: begin
        wr_en  = 1'b1;
        wr_reg = rd;
        case (funct)
          F_ADD:   alu_ctl = ALU_ADD;
          F_SUB:   alu_ctl = ALU_SUB;
          F_AND:   alu_ctl = ALU_AND;
          F_OR:    alu_ctl = ALU_OR;
          F_SLT:   alu_ctl = ALU_SLT;
          default: begin
            illegal = 1'b1;
            wr_en   = 1'b0;
            wr_reg  = 5'd0;
          end
        endcase
      end
      OP_ADDI, OP_LW: begin
        use_imm = 1'b1;
        wr_en   = 1'b1;
        wr_reg  = rt;
      end
      OP_SW: begin
        use_imm = 1'b1;
      end
      OP_BEQ: begin
        alu_ctl   = ALU_SUB;
        is_branch = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctl_sequencer.sv
// rtl/alu_ctl_sequencer.sv - multi-cycle issue stage driving the control side of a 32-bit ALU
//
// Purpose: accepts an instruction plus operands, drives the ALU for one EXEC
//          cycle, captures result/zero and returns a registered response.
// Ports:
//   clk, reset                      clock, async active-high reset
//   instr_valid/instr_ready         request handshake (ready only in IDLE)
//   instr, rs_data, rt_data         instruction word and register operands
//   alu_a, alu_b, alu_ctl           ALU operands and control (ADD/0/0 outside EXEC)
//   alu_result, alu_zero            combinational ALU outputs
//   res_valid/res_ready             response handshake
//   res_data, res_wr_en, res_wr_reg response payload
//   res_branch_taken, res_illegal   response flags
//   retired_cnt, illegal_cnt        saturating completion counters
module alu_ctl_sequencer
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_wr_en,
  output logic [4:0]       res_wr_reg,
  output logic             res_branch_taken,
  output logic             res_illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [31:0] instr_q;
  logic [31:0] rs_q;
  logic [31:0] rt_q;

  // One decoder serves both phases: in IDLE it classifies the incoming word
  // so illegal instructions can skip EXEC; afterwards it sees the latched word.
  logic [31:0] dec_instr;
  logic [3:0]  dec_alu_ctl;
  logic        dec_use_imm;
  logic        dec_wr_en;
  logic [4:0]  dec_wr_reg;
  logic        dec_is_branch;
  logic        dec_illegal;
  logic [31:0] imm_ext;

  assign dec_instr = (state == ST_IDLE) ? instr : instr_q;

  alu_ctl_decode u_decode (
    .instr     (dec_instr),
    .alu_ctl   (dec_alu_ctl),
    .use_imm   (dec_use_imm),
    .wr_en     (dec_wr_en),
    .wr_reg    (dec_wr_reg),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  assign imm_ext = {{16{instr_q[15]}}, instr_q[15:0]};

  assign instr_ready = (state == ST_IDLE);
  assign res_valid   = (state == ST_RESP);

  // ALU operands only come from registered state, so they fall back to
  // ADD/0/0 the instant reset forces the state to IDLE.
  always_comb begin
    alu_ctl = ALU_ADD;
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    if (state == ST_EXEC) begin
      alu_ctl = dec_alu_ctl;
      alu_a   = rs_q;
      alu_b   = dec_use_imm ? imm_ext : rt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      instr_q          <= 32'd0;
      rs_q             <= 32'd0;
      rt_q             <= 32'd0;
      res_data         <= 32'd0;
      res_wr_en        <= 1'b0;
      res_wr_reg       <= 5'd0;
      res_branch_taken <= 1'b0;
      res_illegal      <= 1'b0;
      retired_cnt      <= '0;
      illegal_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            rs_q    <= rs_data;
            rt_q    <= rt_data;
            if (dec_illegal) begin
              res_data         <= 32'd0;
              res_wr_en        <= 1'b0;
              res_wr_reg       <= 5'd0;
              res_branch_taken <= 1'b0;
              res_illegal      <= 1'b1;
              state            <= ST_RESP;
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          res_data         <= alu_result;
          res_wr_en        <= dec_wr_en;
          res_wr_reg       <= dec_wr_reg;
          res_branch_taken <= dec_is_branch & alu_zero;
          res_illegal      <= 1'b0;
          state            <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            state <= ST_IDLE;
            if (res_illegal) begin
              if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_ONE;
            end else begin
              if (retired_cnt != '1) retired_cnt <= retired_cnt + CNT_ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
